// File: rtl/cosine_distance_engine.sv
// rtl/cosine_distance_engine.sv - fixed-point cos(x) by Horner-form Taylor series, scaled by v
// One shared WIDTH x WIDTH multiplier; two cycles per series term.
module cosine_distance_engine #(
   parameter int WIDTH = 16,
   parameter int FRAC  = 14,
   parameter int TERMS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic signed [WIDTH-1:0] x,
   input  logic signed [WIDTH-1:0] v,
   output logic                    busy,
   output logic                    done,
   output logic signed [WIDTH-1:0] cos_out,
   output logic signed [WIDTH-1:0] distance
);
   localparam int PW = 2 * WIDTH;

   function automatic int calc_c(input int k);
      int d;
      d = (2 * k - 1) * (2 * k);
      return ((1 << FRAC) + d / 2) / d;
   endfunction

   localparam logic signed [WIDTH-1:0] C1  = WIDTH'(calc_c(1));
   localparam logic signed [WIDTH-1:0] C2  = WIDTH'(calc_c(2));
   localparam logic signed [WIDTH-1:0] C3  = WIDTH'(calc_c(3));
   localparam logic signed [WIDTH-1:0] C4  = WIDTH'(calc_c(4));
   localparam logic signed [WIDTH-1:0] C5  = WIDTH'(calc_c(5));
   localparam logic signed [WIDTH-1:0] C6  = WIDTH'(calc_c(6));
   localparam logic signed [WIDTH-1:0] ONE = WIDTH'(1 << FRAC);

   typedef enum logic [2:0] {
      S_IDLE, S_SQUARE, S_MULA, S_MULB, S_SCALE, S_DONE
   } state_t;

   state_t                  r_state, w_next;
   logic signed [WIDTH-1:0] r_x, r_v, r_x2, r_t, r_acc;
   logic [2:0]              r_k;
   logic signed [WIDTH-1:0] w_coef, w_op_a, w_op_b;
   logic signed [PW-1:0]    w_prod, w_shift;
   logic signed [PW:0]      w_shift_ext, w_diff;
   logic signed [WIDTH-1:0] w_sat_shift, w_sat_diff;
   logic                    w_accept;

   function automatic logic signed [WIDTH-1:0] sat(input logic signed [PW:0] a);
      logic signed [PW:0] hi, lo;
      hi = '0;
      hi[WIDTH-2:0] = '1;
      lo = '1;
      lo[WIDTH-2:0] = '0;
      if (a > hi)      return hi[WIDTH-1:0];
      else if (a < lo) return lo[WIDTH-1:0];
      else             return a[WIDTH-1:0];
   endfunction

   assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
   assign busy     = (r_state == S_SQUARE) || (r_state == S_MULA) ||
                     (r_state == S_MULB)   || (r_state == S_SCALE);

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: if (start) w_next = S_SQUARE;
         S_SQUARE:       w_next = S_MULA;
         S_MULA:         w_next = S_MULB;
         S_MULB:         w_next = (r_k == 3'd1) ? S_SCALE : S_MULA;
         S_SCALE:        w_next = S_DONE;
         default:        w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_coef = C1;
      case (r_k)
         3'd2:    w_coef = C2;
         3'd3:    w_coef = C3;
         3'd4:    w_coef = C4;
         3'd5:    w_coef = C5;
         3'd6:    w_coef = C6;
         default: w_coef = C1;
      endcase
   end

   // Operand steering for the single shared multiplier
   always_comb begin
      w_op_a = '0;
      w_op_b = '0;
      case (r_state)
         S_SQUARE: begin w_op_a = r_x;  w_op_b = r_x;    end
         S_MULA:   begin w_op_a = r_x2; w_op_b = w_coef; end
         S_MULB:   begin w_op_a = r_t;  w_op_b = r_acc;  end
         S_SCALE:  begin w_op_a = r_v;  w_op_b = r_acc;  end
         default:  begin w_op_a = '0;   w_op_b = '0;     end
      endcase
   end

   assign w_prod      = w_op_a * w_op_b;
   assign w_shift     = w_prod >>> FRAC;
   assign w_shift_ext = {w_shift[PW-1], w_shift};
   assign w_diff      = $signed({{(PW+1-WIDTH){1'b0}}, ONE}) - w_shift_ext;
   assign w_sat_shift = sat(w_shift_ext);
   assign w_sat_diff  = sat(w_diff);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_x      <= '0;
         r_v      <= '0;
         r_x2     <= '0;
         r_t      <= '0;
         r_acc    <= '0;
         r_k      <= '0;
         done     <= 1'b0;
         cos_out  <= '0;
         distance <= '0;
      end else begin
         if (w_accept) begin
            r_x  <= x;
            r_v  <= v;
            done <= 1'b0;
         end
         case (r_state)
            S_SQUARE: begin
               r_x2  <= w_sat_shift;
               r_acc <= ONE;
               r_k   <= 3'(TERMS);
            end
            S_MULA: r_t <= w_sat_shift;
            S_MULB: begin
               r_acc <= w_sat_diff;
               r_k   <= 3'(r_k - 3'd1);
            end
            S_SCALE: begin
               cos_out  <= r_acc;
               distance <= w_sat_shift;
               done     <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_cosine_distance_engine.sv
// tb/tb_cosine_distance_engine.sv - directed bench for cosine_distance_engine (TERMS 4, 1 and 6)
module tb_cosine_distance_engine;
   logic clk = 1'b0;
   logic rst, start;
   logic signed [15:0] x, v;
   int sel = 4;

   logic st4, st1, st6;
   logic busy4, done4, busy1, done1, busy6, done6;
   logic signed [15:0] cos4, dist4, cos1, dist1, cos6, dist6;
   logic w_busy, w_done;
   logic signed [15:0] w_cos, w_dist;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign st4 = start && (sel == 4);
   assign st1 = start && (sel == 1);
   assign st6 = start && (sel == 6);

   cosine_distance_engine #(.WIDTH(16), .FRAC(14), .TERMS(4)) u_d4 (
      .clk(clk), .rst(rst), .start(st4), .x(x), .v(v),
      .busy(busy4), .done(done4), .cos_out(cos4), .distance(dist4));
   cosine_distance_engine #(.WIDTH(16), .FRAC(14), .TERMS(1)) u_d1 (
      .clk(clk), .rst(rst), .start(st1), .x(x), .v(v),
      .busy(busy1), .done(done1), .cos_out(cos1), .distance(dist1));
   cosine_distance_engine #(.WIDTH(16), .FRAC(14), .TERMS(6)) u_d6 (
      .clk(clk), .rst(rst), .start(st6), .x(x), .v(v),
      .busy(busy6), .done(done6), .cos_out(cos6), .distance(dist6));

   always_comb begin
      case (sel)
         1:       begin w_busy = busy1; w_done = done1; w_cos = cos1; w_dist = dist1; end
         6:       begin w_busy = busy6; w_done = done6; w_cos = cos6; w_dist = dist6; end
         default: begin w_busy = busy4; w_done = done4; w_cos = cos4; w_dist = dist4; end
      endcase
   end

   task automatic check_val(input string tag, input longint obs, input longint exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic longint sat16(input longint a);
      if (a > 32767)  return 32767;
      if (a < -32768) return -32768;
      return a;
   endfunction

   task automatic model(input int terms, input longint xi, input longint vi,
                        output longint c, output longint d);
      longint ck [7] = '{0, 8192, 1365, 546, 293, 182, 124};
      longint x2, t, acc;
      x2  = sat16((xi * xi) >>> 14);
      acc = 16384;
      for (int k = terms; k >= 1; k--) begin
         t   = sat16((x2 * ck[k]) >>> 14);
         acc = sat16(16384 - ((t * acc) >>> 14));
      end
      c = acc;
      d = sat16((vi * acc) >>> 14);
   endtask

   task automatic run_calc(input int s, input longint xi, input longint vi, output int lat);
      sel   = s;
      x     = 16'(xi);
      v     = 16'(vi);
      start = 1'b1;
      tick();
      start = 1'b0;
      lat   = 0;
      while (!w_done && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   initial begin
      int lat, ndone, first, second, wait_n;
      longint mc, md, xi, vi;

      rst = 1'b1; start = 1'b0; x = '0; v = '0;
      repeat (3) tick();
      check_val("rst_busy", busy4, 0);
      check_val("rst_done", done4, 0);
      check_val("rst_cos", cos4, 0);
      check_val("rst_dist", dist4, 0);
      rst = 1'b0;
      tick();

      // x=0, v=100: busy through edge 9, done at edge 10
      sel = 4; x = 0; v = 100; start = 1'b1;
      tick();
      start = 1'b0;
      check_val("busy_e0", w_busy, 1);
      for (int e = 1; e <= 10; e++) begin
         tick();
         if (e < 10) begin
            check_val("busy_mid", w_busy, 1);
            check_val("done_early", w_done, 0);
         end
      end
      check_val("done_e10", w_done, 1);
      check_val("busy_e10", w_busy, 0);
      check_val("cos_x0", w_cos, 16384);
      check_val("dist_x0", w_dist, 100);
      tick();
      check_val("done_hold", w_done, 1);
      check_val("cos_hold", w_cos, 16384);

      run_calc(4, 0, 32767, lat);
      check_val("lat_vmax", lat, 10);
      check_val("dist_vmax", w_dist, 32767);
      run_calc(4, 0, -32768, lat);
      check_val("dist_vmin", w_dist, -32768);
      check_val("cos_vmin", w_cos, 16384);

      // pi/2: x^2 saturates in Q2.14, hand-traced Horner gives 2554
      run_calc(4, 25736, 1000, lat);
      check_val("lat_pi2", lat, 10);
      check_val("cos_pi2", w_cos, 2554);
      check_val("dist_pi2", w_dist, 155);
      model(4, 25736, 1000, mc, md);
      check_val("cos_pi2_model", w_cos, mc);
      run_calc(4, -25736, 1000, lat);
      check_val("cos_npi2", w_cos, 2554);
      check_val("dist_npi2", w_dist, 155);

      // start held high 30 edges; operands changed while busy are ignored
      sel = 4; x = 0; v = 100; start = 1'b1;
      ndone = 0; first = -1; second = -1;
      for (int e = 0; e < 30; e++) begin
         tick();
         if (w_done) begin
            if (ndone == 0) first = e;
            else if (ndone == 1) second = e;
            ndone++;
            check_val("cont_cos", w_cos, 16384);
            check_val("cont_dist", w_dist, 100);
         end
         if (e >= 1 && e <= 7) begin x = 25736; v = 1000; end
         else begin x = 0; v = 100; end
      end
      start = 1'b0;
      check_val("cont_ndone", ndone, 2);
      check_val("cont_first", first, 10);
      check_val("cont_second", second, 21);
      wait_n = 0;
      while (!w_done && wait_n < 20) begin tick(); wait_n++; end
      check_val("cont_tail_done", w_done, 1);

      // reset at edge 5 of a calculation
      x = 25736; v = 1000; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_val("abort_busy", w_busy, 0);
      check_val("abort_done", w_done, 0);
      check_val("abort_cos", w_cos, 0);
      check_val("abort_dist", w_dist, 0);
      ndone = 0;
      for (int e = 0; e < 15; e++) begin
         tick();
         if (w_done) ndone++;
      end
      check_val("abort_no_done", ndone, 0);
      run_calc(4, 0, 100, lat);
      check_val("abort_relat", lat, 10);
      check_val("abort_recos", w_cos, 16384);

      // reset wins over start on the same edge
      start = 1'b1; rst = 1'b1;
      tick();
      start = 1'b0; rst = 1'b0;
      check_val("rst_over_start_busy", w_busy, 0);
      check_val("rst_over_start_done", w_done, 0);

      for (int i = 0; i < 256; i++) begin
         xi = -32768 + 257 * i;
         vi = xi >>> 1;
         run_calc(1, xi, vi, lat);
         model(1, xi, vi, mc, md);
         check_val("t1_lat", lat, 4);
         check_val("t1_cos", w_cos, mc);
         check_val("t1_dist", w_dist, md);
      end
      for (int i = 0; i < 256; i++) begin
         xi = -32768 + 257 * i;
         vi = 3000 - (xi >>> 2);
         run_calc(6, xi, vi, lat);
         model(6, xi, vi, mc, md);
         check_val("t6_lat", lat, 14);
         check_val("t6_cos", w_cos, mc);
         check_val("t6_dist", w_dist, md);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
